// File: rtl/edge_cap_pkg.sv
// Shared types and sizing helpers for the edge frame capture block.
package edge_cap_pkg;

  // Top-level controller states.
  typedef enum logic [1:0] {
    IDLE,
    ARM,
    CAPTURE,
    READ
  } state_t;

  // Width of the border band that is blanked when the border mask is built in.
  localparam int BORDER = 2;

  // Default frame geometry.
  localparam int H_RES_DEF = 176;
  localparam int V_RES_DEF = 144;

  // Number of packed bytes in one frame, eight pixels per byte.
  function automatic int frame_bytes(input int h_res, input int v_res);
    return (h_res * v_res) / 8;
  endfunction

  // Bitmap address width for the default geometry.
  localparam int ADDR_W = $clog2(frame_bytes(H_RES_DEF, V_RES_DEF));

endpackage

// File: rtl/edge_bitmap_ram.sv
// Simple dual-port bitmap store: one synchronous write port, one synchronous
// read port with read enable, 8-bit data. The read register holds its value
// while rd_en is low, so it doubles as a pipeline stage for the readout path.
module edge_bitmap_ram
  import edge_cap_pkg::*;
#(
  parameter int DEPTH = frame_bytes(H_RES_DEF, V_RES_DEF),
  parameter int AW    = ADDR_W
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];

  // Write port.
  // NOTE: the array has no reset so it maps onto block RAM; contents are
  // undefined until a frame has been written.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read port; output register only updates on an issued read.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/edge_frame_capture.sv
// Freezes one binary edge frame into an on-chip bitmap (8 pixels per byte,
// LSB = leftmost pixel) and streams it out over a valid/ready byte port.
// Optional build macro: EDGE_BORDER_MASK_EN forces the 2-pixel frame border to 0.
module edge_frame_capture
  import edge_cap_pkg::*;
#(
  parameter int H_RES   = 176,
  parameter int V_RES   = 144,
  parameter int EDGE_TH = 128
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       i_vsync,
  input  logic       i_hsync,
  input  logic       i_de,
  input  logic [7:0] i_data,
  input  logic       i_cap_req,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err,
  output logic       o_rd_valid,
  input  logic       i_rd_ready,
  output logic [7:0] o_rd_data,
  output logic       o_rd_last
);

  localparam int FB = frame_bytes(H_RES, V_RES);
  localparam int AW = $clog2(FB);
  localparam int XW = $clog2(H_RES);
  localparam int YW = $clog2(V_RES);
  localparam logic [7:0]    TH8       = 8'(EDGE_TH);
  localparam logic [XW-1:0] X_LAST    = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_LAST    = YW'(V_RES - 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(FB - 1);

  state_t        state;
  logic          vsync_q;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [7:0]    pack;
  logic [AW-1:0] byte_idx;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic [AW-1:0] rd_addr;
  logic          rd_more;
  logic          ram_vld;
  logic          ram_last;
  logic [7:0]    ram_q;

  logic       vs_rise, vs_fall, pix, frame_end, xfer, ram_take, rd_en;
  logic [7:0] pack_next;

  // Line sync is not needed: position comes from counting i_de cycles.
  logic unused_hsync;
  assign unused_hsync = i_hsync;

  // Pixel threshold, optional border blanking, and sync edge detection.
  // NOTE: every always_comb output gets a default before any conditional
  // override, otherwise a path that skips the assignment infers a latch.
  always_comb begin
    pix = (i_data >= TH8);
`ifdef EDGE_BORDER_MASK_EN
    if (x < XW'(BORDER) || x >= XW'(H_RES - BORDER) ||
        y < YW'(BORDER) || y >= YW'(V_RES - BORDER)) pix = 1'b0;
`endif
    pack_next = {pix, pack[7:1]};
    vs_rise   = i_vsync & ~vsync_q;
    vs_fall   = ~i_vsync & vsync_q;
    frame_end = i_de && (x == X_LAST) && (y == Y_LAST);
  end

  // Readout flow control: RAM output stage feeds a one-entry output register.
  always_comb begin
    xfer     = o_rd_valid & i_rd_ready;
    ram_take = ram_vld & (~o_rd_valid | xfer);
    rd_en    = (state == READ) & rd_more & (~ram_vld | ram_take);
  end

  edge_bitmap_ram #(
    .DEPTH (FB),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (ram_q)
  );

  // Controller: arm, capture/pack, and stream the bitmap out.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      vsync_q    <= 1'b0;
      x          <= '0;
      y          <= '0;
      pack       <= '0;
      byte_idx   <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      rd_addr    <= '0;
      rd_more    <= 1'b0;
      ram_vld    <= 1'b0;
      ram_last   <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_err      <= 1'b0;
      o_rd_valid <= 1'b0;
      o_rd_data  <= '0;
      o_rd_last  <= 1'b0;
    end else begin
      vsync_q <= i_vsync;
      o_done  <= 1'b0;
      wr_en   <= 1'b0;
      case (state)
        IDLE: begin
          if (i_cap_req) begin
            state  <= ARM;
            o_busy <= 1'b1;
            o_err  <= 1'b0;
          end
        end
        ARM: begin
          if (vs_fall) begin
            state    <= CAPTURE;
            x        <= '0;
            y        <= '0;
            byte_idx <= '0;
          end
        end
        CAPTURE: begin
          if (i_de) begin
            pack <= pack_next;
            if (x == X_LAST) begin
              x <= '0;
              y <= y + YW'(1);
            end else begin
              x <= x + XW'(1);
            end
            if (x[2:0] == 3'd7) begin
              wr_en    <= 1'b1;
              wr_addr  <= byte_idx;
              wr_data  <= pack_next;
              byte_idx <= byte_idx + AW'(1);
            end
          end
          // A completed frame wins over a coincident vsync rise.
          if (frame_end) begin
            state   <= READ;
            rd_addr <= '0;
            rd_more <= 1'b1;
            ram_vld <= 1'b0;
          end else if (vs_rise) begin
            o_err <= 1'b1;
            state <= ARM;
          end
        end
        READ: begin
          if (rd_en) begin
            rd_addr  <= rd_addr + AW'(1);
            ram_vld  <= 1'b1;
            ram_last <= (rd_addr == LAST_ADDR);
            if (rd_addr == LAST_ADDR) rd_more <= 1'b0;
          end else if (ram_take) begin
            ram_vld <= 1'b0;
          end
          if (ram_take) begin
            o_rd_valid <= 1'b1;
            o_rd_data  <= ram_q;
            o_rd_last  <= ram_last;
          end else if (xfer) begin
            o_rd_valid <= 1'b0;
          end
          if (xfer && o_rd_last) begin
            state      <= IDLE;
            o_busy     <= 1'b0;
            o_done     <= 1'b1;
            o_rd_valid <= 1'b0;
            o_rd_last  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/edge_frame_capture.md
# edge_frame_capture

Sits directly downstream of the Canny edge stage and freezes one binary edge frame for the pen-plotter path.
- On request, it arms, waits for a frame boundary, and thresholds each pixel to 1 bit.
- It packs 8 pixels per byte into an on-chip bitmap and then streams the bitmap out over a valid/ready byte interface to the plotter/UART path.

## Interface
- H_RES, 176, active pixels per line; must be a multiple of 8
- V_RES, 144, active lines per frame
- EDGE_TH, 128, pixel is an edge when i_data >= EDGE_TH
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- i_vsync  in  1  vertical sync from edge stage, active-high during vertical blanking pulse
- i_hsync  in  1  horizontal sync; not used for counting, ignored
- i_de  in  1  pixel valid
- i_data  in  8  edge pixel (0x00/0xFF nominal)
- i_cap_req  in  1  one-cycle capture request
- o_busy  out  1  high in any state except IDLE
- o_done  out  1  one-cycle pulse after last byte accepted
- o_err  out  1  sticky short-frame flag; cleared by next accepted i_cap_req
- o_rd_valid  out  1  readout byte valid
- i_rd_ready  in  1  consumer ready
- o_rd_data  out  8  packed pixels, bit k = pixel x%8==k (LSB = leftmost)
- o_rd_last  out  1  high with final byte (index FRAME_BYTES-1)

## Operation
- FRAME_BYTES = H_RES*V_RES/8 (3168 default).
- Bitmap byte address = y*H_RES/8 + x/8, row-major.
- States:
  - IDLE: i_cap_req -> ARM, clears o_err. i_cap_req in any other state is ignored.
  - ARM: waits for a falling edge of i_vsync (registered compare), then -> CAPTURE with x=y=0.
  - CAPTURE: each i_de cycle shifts bit (i_data >= EDGE_TH) into the pack register.
    - x wraps at H_RES-1 and increments y.
    - On the 8th bit, the byte is written to the RAM.
    - After pixel (H_RES-1, V_RES-1) -> READ.
    - A rising edge of i_vsync before the frame completes means a short frame: set o_err, drop the partial frame, -> ARM (automatic retry).
  - READ: sequential RAM reads 0..FRAME_BYTES-1 through a one-entry output register.
    - Data is held stable while o_rd_valid && !i_rd_ready.
    - Transfer occurs on o_rd_valid && i_rd_ready.
    - After the last byte transfers -> IDLE and o_done pulses.
- Input sync/de are ignored outside CAPTURE; the upstream stream never stalls.
- Reset mid-operation returns to IDLE. RAM contents are undefined afterwards and are not cleared.

## Timing
- Reset values: o_busy=0, o_done=0, o_err=0, o_rd_valid=0, o_rd_data=0, o_rd_last=0.
- o_busy rises the cycle after i_cap_req is sampled in IDLE.
- RAM write occurs the cycle after the 8th pixel of a byte is sampled.
- Entry to READ is the cycle after the last pixel is sampled.
- First o_rd_valid is 2 cycles after entering READ (address issue + sync RAM read).
- With i_rd_ready held high: 1 byte/cycle sustained, and o_rd_last is on cycle FRAME_BYTES+1 after READ entry.
- The read address advances only on a transfer or while the output register is empty. No bubble and no duplicate on ready toggling.
- o_done is asserted the cycle after the last transfer, with o_busy=0 in the same cycle.
- If a vsync rising edge and the final pixel occur in the same cycle, the frame is complete: go to READ, no error.

## Configuration
- EDGE_BORDER_MASK_EN defined: pixels with x<2, x>=H_RES-2, y<2 or y>=V_RES-2 are forced to 0 before packing. This suppresses Canny warm-up garbage on the border.
- Not defined: every pixel is packed unmodified.
- Latency is identical either way.

## Structure
- Package edge_cap_pkg:
  - state enum (IDLE, ARM, CAPTURE, READ)
  - function frame_bytes(H_RES,V_RES)
  - ADDR_W = $clog2(frame_bytes)
  - BORDER = 2
- Sub-module edge_bitmap_ram: simple dual-port BRAM with one synchronous write port, one synchronous read port, 8-bit data, depth FRAME_BYTES.
- FSM, counters, pack register and readout register stay in edge_frame_capture.

## Test plan
- Synthetic frame with only pixel (0,0)=0xFF, border mask off -> byte0=0x01, all other bytes 0x00, o_rd_last on byte 3167, o_done one pulse, o_err=0.
- Ramp i_data=x in each line, EDGE_TH=128 -> bytes 16..21 of every row = 0xFF, bytes 0..15 = 0x00. Checks pixels 128..175 set and 127 clear.
- i_rd_ready random 50% toggling -> byte sequence identical to the ready-high run, and no byte repeated or lost.
- i_vsync rising after 100 lines -> o_err=1, state returns to ARM, next full frame captured correctly with o_err held until the next request.
- With EDGE_BORDER_MASK_EN and an all-0xFF frame -> row 0/1/142/143 bytes all 0x00. Interior rows: first byte 0xFC, last byte 0x3F, others 0xFF.
- rstn asserted mid-CAPTURE, then a new i_cap_req -> all outputs return to 0 immediately, then a clean full capture/readout follows.
